// File: rtl/fifo_pkg.sv
// Shared sizing constants and helpers for the parametrised lane FIFOs.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH = 6;
    localparam int DEF_ADDR_WIDTH = 2;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

    // One extra bit so the count can represent a completely full FIFO.
    function automatic int cnt_width_of(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Dual-port register array: synchronous write, combinational read.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with access protection, sticky errors,
// programmable thresholds and a registered read strobe.
module param_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int CNT_WIDTH  = cnt_width_of(ADDR_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_enable,
    input  logic                  rd_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CNT_WIDTH-1:0]  umbral_af,
    input  logic [CNT_WIDTH-1:0]  umbral_ae,
    input  logic                  err_clear,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full_fifo,
    output logic                  empty_fifo,
    output logic                  almost_full_fifo,
    output logic                  almost_empty_fifo,
    output logic                  overflow_err,
    output logic                  underflow_err,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  fill_level
);

    localparam logic [CNT_WIDTH-1:0] DEPTH_C =
        CNT_WIDTH'(depth_of(ADDR_WIDTH));

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  count;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_acc;
    logic                  wr_acc;

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .wen  (wr_acc),
        .waddr(wr_ptr),
        .wdata(data_in),
        .raddr(rd_ptr),
        .rdata(rd_word)
    );

    // A write into a full FIFO is allowed when a read frees a slot.
    assign rd_acc = rd_enable & ~empty_fifo;
    assign wr_acc = wr_enable & (~full_fifo | rd_acc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            data_out      <= '0;
            valid_out     <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + 1'b1;
                data_out <= rd_word;
            end
            valid_out <= rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Set has priority over clear.
            overflow_err  <= (wr_enable & ~wr_acc)
                           | (overflow_err & ~err_clear);
            underflow_err <= (rd_enable & ~rd_acc)
                           | (underflow_err & ~err_clear);
        end
    end

    assign fill_level        = count;
    assign full_fifo         = (count == DEPTH_C);
    assign empty_fifo        = (count == '0);
    assign almost_full_fifo  = (count >= umbral_af);
    assign almost_empty_fifo = (count <= umbral_ae);
    assign error             = overflow_err | underflow_err;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo with a queue-based reference model.
module tb_param_fifo;

    localparam int DW    = 6;
    localparam int AW    = 2;
    localparam int CW    = 3;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_enable = 1'b0;
    logic          rd_enable = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [CW-1:0] umbral_af = 3'd3;
    logic [CW-1:0] umbral_ae = 3'd1;
    logic          err_clear = 1'b0;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full_fifo;
    logic          empty_fifo;
    logic          almost_full_fifo;
    logic          almost_empty_fifo;
    logic          overflow_err;
    logic          underflow_err;
    logic          error;
    logic [CW-1:0] fill_level;

    int errors = 0;
    int checks = 0;

    param_fifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_enable        (wr_enable),
        .rd_enable        (rd_enable),
        .data_in          (data_in),
        .umbral_af        (umbral_af),
        .umbral_ae        (umbral_ae),
        .err_clear        (err_clear),
        .data_out         (data_out),
        .valid_out        (valid_out),
        .full_fifo        (full_fifo),
        .empty_fifo       (empty_fifo),
        .almost_full_fifo (almost_full_fifo),
        .almost_empty_fifo(almost_empty_fifo),
        .overflow_err     (overflow_err),
        .underflow_err    (underflow_err),
        .error            (error),
        .fill_level       (fill_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Reference model: a queue of stored words plus sticky bits.
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_valid = 0;
    bit            m_ovf = 0;
    bit            m_unf = 0;

    always @(negedge reset) begin
        q.delete();
        m_dout  = '0;
        m_valid = 0;
        m_ovf   = 0;
        m_unf   = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            bit got_rd;
            bit got_wr;
            got_rd = rd_enable && (q.size() > 0);
            got_wr = wr_enable && ((q.size() < DEPTH) || got_rd);
            m_valid = got_rd;
            if (got_rd) m_dout = q.pop_front();
            if (got_wr) q.push_back(data_in);
            m_ovf = (wr_enable && !got_wr) || (m_ovf && !err_clear);
            m_unf = (rd_enable && !got_rd) || (m_unf && !err_clear);
        end
    end

    always @(negedge clk) begin
        int n;
        n = q.size();
        chk("fill", int'(fill_level), n);
        chk("full", int'(full_fifo), int'(n == DEPTH));
        chk("empty", int'(empty_fifo), int'(n == 0));
        chk("afull", int'(almost_full_fifo), int'(n >= int'(umbral_af)));
        chk("aempty", int'(almost_empty_fifo), int'(n <= int'(umbral_ae)));
        chk("valid", int'(valid_out), int'(m_valid));
        chk("dout", int'(data_out), int'(m_dout));
        chk("ovf", int'(overflow_err), int'(m_ovf));
        chk("unf", int'(underflow_err), int'(m_unf));
        chk("err", int'(error), int'(m_ovf | m_unf));
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        wr_enable = 1'b0;
        rd_enable = 1'b0;
        err_clear = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_empty", int'(empty_fifo), 1);
        chk("rst_full", int'(full_fifo), 0);
        chk("rst_err", int'(error), 0);
        chk("rst_valid", int'(valid_out), 0);
        #9 reset = 1'b1;

        for (int i = 0; i < 4; i++) begin
            wr_enable = 1'b1;
            data_in   = DW'(i + 1);
            tick();
            chk("t1_fill", int'(fill_level), i + 1);
            chk("t1_af", int'(almost_full_fifo), int'(i + 1 >= 3));
        end
        chk("t1_full", int'(full_fifo), 1);

        data_in = 6'h3F;
        tick();
        idle();
        chk("t2_ovf", int'(overflow_err), 1);
        chk("t2_err", int'(error), 1);
        chk("t2_fill", int'(fill_level), 4);
        for (int i = 0; i < 4; i++) begin
            rd_enable = 1'b1;
            tick();
            chk("t2_valid", int'(valid_out), 1);
            chk("t2_data", int'(data_out), i + 1);
        end
        idle();
        tick();
        chk("t2_vlow", int'(valid_out), 0);
        chk("t2_hold", int'(data_out), 4);

        err_clear = 1'b1;
        tick();
        idle();
        chk("t5_clr", int'(error), 0);

        for (int i = 0; i < 4; i++) begin
            wr_enable = 1'b1;
            data_in   = DW'(16 + i);
            tick();
        end
        rd_enable = 1'b1;
        data_in   = 6'h2A;
        tick();
        chk("t3_fill", int'(fill_level), 4);
        chk("t3_data", int'(data_out), 16);
        chk("t3_err", int'(error), 0);
        wr_enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t3_drain", int'(data_out), (i < 3) ? 17 + i : 42);
        end
        idle();

        wr_enable = 1'b1;
        rd_enable = 1'b1;
        data_in   = 6'h15;
        tick();
        chk("t4_fill", int'(fill_level), 1);
        chk("t4_unf", int'(underflow_err), 1);
        chk("t4_valid", int'(valid_out), 0);
        wr_enable = 1'b0;
        tick();
        chk("t4_data", int'(data_out), 21);
        idle();

        err_clear = 1'b1;
        rd_enable = 1'b1;
        tick();
        chk("t5_setwins", int'(underflow_err), 1);
        rd_enable = 1'b0;
        tick();
        chk("t5_clr2", int'(underflow_err), 0);
        idle();

        umbral_af = 3'd0;
        umbral_ae = 3'd5;
        #1;
        chk("thr_af0", int'(almost_full_fifo), 1);
        chk("thr_ae5", int'(almost_empty_fifo), 1);
        umbral_af = 3'd3;
        umbral_ae = 3'd1;

        wr_enable = 1'b1;
        data_in   = 6'h20;
        tick();
        rd_enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            data_in = DW'(32 + i);
            tick();
            chk("t6_wrap", int'(data_out), 31 + i);
        end
        rd_enable = 1'b0;
        data_in   = 6'h2B;
        tick();
        data_in   = 6'h2C;
        tick();
        wr_enable = 1'b0;
        rd_enable = 1'b1;
        tick();
        rd_enable = 1'b0;
        chk("t6_pre_fill", int'(fill_level), 2);
        chk("t6_pre_valid", int'(valid_out), 1);
        #1 reset = 1'b0;
        #1;
        chk("t6_rst_empty", int'(empty_fifo), 1);
        chk("t6_rst_valid", int'(valid_out), 0);
        chk("t6_rst_fill", int'(fill_level), 0);
        tick();
        #3 reset = 1'b1;

        wr_enable = 1'b1;
        data_in   = 6'h07;
        tick();
        chk("t6_fresh_fill", int'(fill_level), 1);
        wr_enable = 1'b0;
        rd_enable = 1'b1;
        tick();
        chk("t6_fresh_data", int'(data_out), 7);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
